// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the FFT stage sequencer: FSM states, pipeline latency
// and width helpers.
package fft_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Ceiling log2, never below one bit so derived vectors stay legal.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) bits = i + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

    function automatic int unsigned pipe_lat(input int unsigned mem_lat,
                                             input int unsigned bfly_lat);
        return mem_lat + bfly_lat;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_addr_delay.sv
// LAT-deep shift register carrying {valid, bank, addr_a, addr_b} from the read
// issue point to the write-back point.
module fft_addr_delay #(
    parameter int unsigned LAT = 6,
    parameter int unsigned AW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_bank,
    input  logic [AW-1:0] in_addr_a,
    input  logic [AW-1:0] in_addr_b,
    output logic          out_valid,
    output logic          out_bank,
    output logic [AW-1:0] out_addr_a,
    output logic [AW-1:0] out_addr_b
);

    logic [LAT-1:0]         valid_q;
    logic [LAT-1:0]         bank_q;
    logic [LAT-1:0][AW-1:0] addr_a_q;
    logic [LAT-1:0][AW-1:0] addr_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            bank_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            valid_q[0]  <= in_valid;
            bank_q[0]   <= in_bank;
            addr_a_q[0] <= in_addr_a;
            addr_b_q[0] <= in_addr_b;
            for (int unsigned i = 1; i < LAT; i++) begin
                valid_q[i]  <= valid_q[i-1];
                bank_q[i]   <= bank_q[i-1];
                addr_a_q[i] <= addr_a_q[i-1];
                addr_b_q[i] <= addr_b_q[i-1];
            end
        end
    end

    always_comb begin
        out_valid  = valid_q[LAT-1];
        out_bank   = valid_q[LAT-1] & bank_q[LAT-1];
        out_addr_a = valid_q[LAT-1] ? addr_a_q[LAT-1] : '0;
        out_addr_b = valid_q[LAT-1] ? addr_b_q[LAT-1] : '0;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT stage sequencer: issues one butterfly per cycle over ping-pong
// banks, delay-matches write-back, drains between stages and pulses done.
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int unsigned LOG2N    = 4,
    parameter int unsigned BFLY_LAT = 5,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic                           rd_bank,
    output logic [LOG2N-1:0]               rd_addr_a,
    output logic [LOG2N-1:0]               rd_addr_b,
    output logic [LOG2N-2:0]               tw_addr,
    output logic                           wr_en,
    output logic                           wr_bank,
    output logic [LOG2N-1:0]               wr_addr_a,
    output logic [LOG2N-1:0]               wr_addr_b,
    output logic [clog2_min1(LOG2N)-1:0]   stage
);

    localparam int unsigned HALF = 1 << (LOG2N - 1);
    localparam int unsigned LAT  = pipe_lat(MEM_LAT, BFLY_LAT);
    localparam int unsigned SW   = clog2_min1(LOG2N);
    localparam int unsigned JW   = LOG2N - 1;
    localparam int unsigned TW   = LOG2N - 1;
    localparam int unsigned DW   = clog2_min1(LAT);

    seq_state_t      state, state_nxt;
    logic [SW-1:0]   stage_q, stage_nxt;
    logic [JW-1:0]   j_q, j_nxt;
    logic [DW-1:0]   drain_q, drain_nxt;

    logic [LOG2N-1:0] j_ext, span, pos, grp, addr_a;
    logic [TW-1:0]    tw_full;
    logic             issuing;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= ST_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            state   <= state_nxt;
            stage_q <= stage_nxt;
            j_q     <= j_nxt;
            drain_q <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_q;
        j_nxt     = j_q;
        drain_nxt = drain_q;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                    stage_nxt = '0;
                    j_nxt     = '0;
                end
            end
            ST_ISSUE: begin
                if (j_q == JW'(HALF - 1)) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = '0;
                end else begin
                    j_nxt = j_q + JW'(1);
                end
            end
            ST_DRAIN: begin
                // LAT drain cycles end exactly on the stage's last write-back.
                if (drain_q == DW'(LAT - 1)) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ISSUE;
                        stage_nxt = stage_q + SW'(1);
                        j_nxt     = '0;
                    end
                end else begin
                    drain_nxt = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                // A start level still high here launches back-to-back transforms.
                if (start) begin
                    state_nxt = ST_ISSUE;
                    stage_nxt = '0;
                    j_nxt     = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        issuing = (state == ST_ISSUE);
        j_ext   = {1'b0, j_q};
        span    = LOG2N'(1) << stage_q;
        pos     = j_ext & (span - LOG2N'(1));
        grp     = j_ext >> stage_q;
        addr_a  = ((grp << stage_q) << 1) | pos;
        tw_full = TW'(pos << (SW'(LOG2N - 1) - stage_q));

        busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
        done      = (state == ST_DONE);
        rd_en     = issuing;
        rd_bank   = stage_q[0];
        rd_addr_a = issuing ? addr_a : '0;
        rd_addr_b = issuing ? (addr_a + span) : '0;
        tw_addr   = issuing ? tw_full : '0;
        stage     = stage_q;
    end

    fft_addr_delay #(
        .LAT (LAT),
        .AW  (LOG2N)
    ) u_addr_delay (
        .clk        (Clk),
        .rst_n      (Rst),
        .in_valid   (rd_en),
        .in_bank    (~rd_bank),
        .in_addr_a  (rd_addr_a),
        .in_addr_b  (rd_addr_b),
        .out_valid  (wr_en),
        .out_bank   (wr_bank),
        .out_addr_a (wr_addr_a),
        .out_addr_b (wr_addr_b)
    );

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: cycle-position reference model
// plus directed literal checks and randomized start/reset stimulus.
module tb_fft_stage_sequencer;

    localparam int LOG2N = 4;
    localparam int HALF  = 8;
    localparam int LAT   = 6;
    localparam int P     = HALF + LAT;
    localparam int TOT   = LOG2N * P;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, rd_en, rd_bank, wr_en, wr_bank;
    logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [2:0] tw_addr;
    logic [1:0] stage;

    int checks = 0;
    int errors = 0;
    int mt = 0;

    int r_busy[0:127], r_done[0:127], r_rd[0:127], r_wr[0:127];
    int r_ra[0:127], r_rb[0:127], r_tw[0:127], r_rbank[0:127];
    int r_wa[0:127], r_wbank[0:127];

    always #5 Clk = ~Clk;

    fft_stage_sequencer #(
        .LOG2N    (4),
        .BFLY_LAT (5),
        .MEM_LAT  (1)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Butterfly j of stage s pairs points differing only in bit s.
    function automatic void model_addr(input int s, input int j,
                                       output int a, output int b, output int tw);
        int span;
        span = 1 << s;
        a  = (j / span) * 2 * span + (j % span);
        b  = a + span;
        tw = (j % span) * (HALF / span);
    endfunction

    // mt: 0 idle, 1..TOT busy cycle index, TOT+1 done cycle.
    always @(posedge Clk) begin
        if (!Rst)              mt <= 0;
        else if (mt == 0)      mt <= start ? 1 : 0;
        else if (mt <= TOT)    mt <= mt + 1;
        else                   mt <= start ? 1 : 0;
    end

    always @(negedge Clk) begin
        int s, k, ws, wk, a, b, tw;
        int exp_busy, exp_done, exp_rd, exp_wr;
        s = 0; k = 0; ws = 0; wk = 0; a = 0; b = 0; tw = 0;
        if (!Rst) begin
            check("reset_outputs",
                  int'({busy, done, rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr,
                        wr_en, wr_bank, wr_addr_a, wr_addr_b, stage}), 0);
        end else begin
            exp_busy = (mt >= 1 && mt <= TOT) ? 1 : 0;
            exp_done = (mt == TOT + 1) ? 1 : 0;
            exp_rd = 0;
            exp_wr = 0;
            if (exp_busy != 0) begin
                s = (mt - 1) / P;
                k = (mt - 1) % P;
                exp_rd = (k < HALF) ? 1 : 0;
            end
            if (mt - LAT >= 1 && mt - LAT <= TOT) begin
                ws = (mt - LAT - 1) / P;
                wk = (mt - LAT - 1) % P;
                exp_wr = (wk < HALF) ? 1 : 0;
            end
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("rd_en", rd_en, exp_rd);
            check("wr_en", wr_en, exp_wr);
            if (exp_busy != 0) check("stage", stage, s);
            if (exp_rd != 0) begin
                model_addr(s, k, a, b, tw);
                check("rd_bank", rd_bank, s % 2);
                check("rd_addr_a", rd_addr_a, a);
                check("rd_addr_b", rd_addr_b, b);
                check("tw_addr", tw_addr, tw);
            end
            if (exp_wr != 0) begin
                model_addr(ws, wk, a, b, tw);
                check("wr_bank", wr_bank, 1 - (ws % 2));
                check("wr_addr_a", wr_addr_a, a);
                check("wr_addr_b", wr_addr_b, b);
            end
        end
    end

    task automatic rec(input int t);
        r_busy[t]  = busy;
        r_done[t]  = done;
        r_rd[t]    = rd_en;
        r_wr[t]    = wr_en;
        r_ra[t]    = rd_addr_a;
        r_rb[t]    = rd_addr_b;
        r_tw[t]    = tw_addr;
        r_rbank[t] = rd_bank;
        r_wa[t]    = wr_addr_a;
        r_wbank[t] = wr_bank;
    endtask

    task automatic count_range(input int lo, input int hi,
                               output int nrd, output int nwr, output int ndone,
                               output int nbusy);
        nrd = 0; nwr = 0; ndone = 0; nbusy = 0;
        for (int t = lo; t <= hi; t++) begin
            nrd   += r_rd[t];
            nwr   += r_wr[t];
            ndone += r_done[t];
            nbusy += r_busy[t];
        end
    endtask

    initial begin
        int nrd, nwr, ndone, nbusy, rst_left, hold;
        rst_left = 0;
        hold = 0;

        repeat (3) @(negedge Clk);
        #1 Rst = 1'b1;

        // Single-cycle start with an ignored start pulse at cycle 20.
        @(negedge Clk);
        #1 start = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge Clk);
            rec(t);
            #1 start = (t == 20);
        end
        count_range(1, 60, nrd, nwr, ndone, nbusy);
        check("run1_rd_pulses", nrd, 32);
        check("run1_wr_pulses", nwr, 32);
        check("run1_done_pulses", ndone, 1);
        check("run1_busy_cycles", nbusy, 56);
        check("run1_busy_c1", r_busy[1], 1);
        check("run1_busy_c56", r_busy[56], 1);
        check("run1_busy_c57", r_busy[57], 0);
        check("run1_done_c57", r_done[57], 1);
        check("run1_busy_c58", r_busy[58], 0);
        check("s0j3_a", r_ra[4], 6);
        check("s0j3_b", r_rb[4], 7);
        check("s0j3_tw", r_tw[4], 0);
        check("s1j3_a", r_ra[18], 5);
        check("s1j3_b", r_rb[18], 7);
        check("s1j3_tw", r_tw[18], 4);
        check("s2j5_a", r_ra[34], 9);
        check("s2j5_b", r_rb[34], 13);
        check("s2j5_tw", r_tw[34], 2);
        check("s3j5_a", r_ra[48], 5);
        check("s3j5_b", r_rb[48], 13);
        check("s3j5_tw", r_tw[48], 5);
        check("s0j3_wb_addr_c10", r_wa[10], 6);
        check("drain_wr_c14", r_wr[14], 1);
        check("drain_wr_c15", r_wr[15], 0);
        check("drain_rd_c14", r_rd[14], 0);
        check("drain_rd_c15", r_rd[15], 1);
        check("drain_rbank_c15", r_rbank[15], 1);
        check("final_wbank_c56", r_wbank[56], 0);

        // Held start: back-to-back transforms.
        #1 start = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge Clk);
            rec(t);
        end
        #1 start = 1'b0;
        check("held_done_c57", r_done[57], 1);
        check("held_busy_c57", r_busy[57], 0);
        check("held_busy_c58", r_busy[58], 1);
        check("held_rd_c58", r_rd[58], 1);
        check("held_rb_c58", r_rb[58], 1);
        repeat (60) @(negedge Clk);

        // Reset mid-operation at cycle 30 for two cycles.
        #1 start = 1'b1;
        for (int t = 1; t <= 110; t++) begin
            @(negedge Clk);
            rec(t);
            #1;
            start = 1'b0;
            if (t == 30) Rst = 1'b0;
            if (t == 32) Rst = 1'b1;
        end
        check("rst_busy_c30", r_busy[30], 1);
        count_range(31, 110, nrd, nwr, ndone, nbusy);
        check("rst_wr_after", nwr, 0);
        check("rst_done_after", ndone, 0);
        check("rst_busy_after", nbusy, 0);

        // Clean transform after the reset.
        start = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge Clk);
            rec(t);
            #1 start = 1'b0;
        end
        count_range(1, 60, nrd, nwr, ndone, nbusy);
        check("run4_rd_pulses", nrd, 32);
        check("run4_wr_pulses", nwr, 32);
        check("run4_done_c57", r_done[57], 1);
        check("run4_done_pulses", ndone, 1);

        // Randomized start pulses, held-start spells and short resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge Clk);
            #1;
            if ($urandom_range(0, 199) == 0) hold = 1 - hold;
            start = (hold != 0) || ($urandom_range(0, 7) == 0);
            if (rst_left > 0) begin
                Rst = 1'b0;
                rst_left--;
            end else begin
                Rst = 1'b1;
                if ($urandom_range(0, 299) == 0) begin
                    Rst = 1'b0;
                    rst_left = $urandom_range(0, 2);
                end
            end
        end
        Rst = 1'b1;
        start = 1'b0;
        repeat (80) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
